// File: rtl/scan_decoder.sv
// scan_decoder: binary-to-one-hot decoder with a prescaled scan engine.
//
// Ports
//   clk      sole clock, rising edge
//   reset_n  asynchronous active-low reset
//   en       enable; 0 blanks bcode and freezes idx/prescaler
//   mode     00 direct, 01 scan-up, 10 scan-down, 11 hold
//   in       binary select used in direct mode
//   bcode    registered one-hot decode of idx (all-zero when disabled)
//   idx      registered current binary index
//   wrap     registered one-cycle pulse on scan wrap-around
//
// Parameters
//   N         select width (1..6), bcode is 2**N wide
//   SCAN_DIV  clock cycles per scan step (1..65535)
module scan_decoder #(
  parameter int N        = 3,
  parameter int SCAN_DIV = 4
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              en,
  input  logic [1:0]        mode,
  input  logic [N-1:0]      in,
  output logic [2**N-1:0]   bcode,
  output logic [N-1:0]      idx,
  output logic              wrap
);

  localparam int W  = 2**N;
  localparam int PW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

  localparam logic [PW-1:0] PRE_MAX = PW'(SCAN_DIV - 1);
  localparam logic [N-1:0]  IDX_MAX = {N{1'b1}};

  localparam logic [1:0] M_DIRECT = 2'b00;
  localparam logic [1:0] M_UP     = 2'b01;
  localparam logic [1:0] M_DOWN   = 2'b10;
  localparam logic [1:0] M_HOLD   = 2'b11;

  logic [PW-1:0] pre, npre;
  logic [1:0]    mode_q;
  logic [N-1:0]  nidx;
  logic          nwrap;
  logic          mode_chg;

  assign mode_chg = (mode != mode_q);

  always_comb begin
    nidx  = idx;
    npre  = pre;
    nwrap = 1'b0;
    if (en) begin
      case (mode)
        M_DIRECT: begin
          nidx = in;
          npre = '0;
        end
        M_UP, M_DOWN: begin
          // A mode switch restarts the prescaler and suppresses the step.
          if (mode_chg) begin
            npre = '0;
          end else if (pre == PRE_MAX) begin
            npre = '0;
            if (mode == M_UP) begin
              nidx  = idx + 1'b1;
              nwrap = (idx == IDX_MAX);
            end else begin
              nidx  = idx - 1'b1;
              nwrap = (idx == '0);
            end
          end else begin
            npre = pre + 1'b1;
          end
        end
        M_HOLD: begin
          if (mode_chg) npre = '0;
        end
        default: ;
      endcase
    end
  end

  // mode_q tracks mode every cycle, so a mode change made while disabled
  // is not seen as a switch on re-enable; the frozen count resumes.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      idx    <= '0;
      pre    <= '0;
      mode_q <= M_DIRECT;
      bcode  <= '0;
      wrap   <= 1'b0;
    end else begin
      idx    <= nidx;
      pre    <= npre;
      mode_q <= mode;
      bcode  <= en ? (W'(1) << nidx) : '0;
      wrap   <= nwrap;
    end
  end

endmodule

// File: doc/scan_decoder.md
SCAN_DECODER -- requirements
Module: scan_decoder

Interface
REQ-001 Parameter N, default 3, select width; output width is 2**N; legal range 1..6.
REQ-002 Parameter SCAN_DIV, default 4, clock cycles per scan step; legal range 1..65535.
REQ-003 clk  input  1  sole clock, all state updates on rising edge.
REQ-004 reset_n  input  1  asynchronous, active-low reset.
REQ-005 en  input  1  decoder enable; 0 blanks the output and freezes the scan.
REQ-006 mode  input  2  00 direct, 01 scan-up, 10 scan-down, 11 hold.
REQ-007 in  input  N  binary select, used in direct mode only.
REQ-008 bcode  output  2**N  registered one-hot code; all-zero when disabled.
REQ-009 idx  output  N  registered current binary index driving bcode.
REQ-010 wrap  output  1  registered one-cycle pulse on scan wrap-around.

Function
REQ-011 Internal state SHALL be idx register, prescaler counter (ceil(log2(SCAN_DIV)) bits, minimum 1 bit), mode_q register holding the previous cycle's mode, and the registered outputs.
REQ-012 Next index nidx SHALL be computed each cycle as follows; on every rising edge, idx SHALL be loaded with nidx.
REQ-013 Direct mode with en=1: nidx = in; bcode SHALL show the decode of in sampled at edge k immediately after edge k (latency 1 clock).
REQ-014 Scan-up with en=1: when prescaler = SCAN_DIV-1, nidx = idx+1 modulo 2**N and prescaler returns to 0; otherwise nidx = idx and prescaler increments.
REQ-015 Scan-down with en=1: same timing as REQ-014, with nidx = idx-1 modulo 2**N.
REQ-016 SCAN_DIV=1: a scan step SHALL occur on every enabled edge.
REQ-017 Hold mode: nidx = idx and prescaler is held; bcode SHALL keep the decode of idx while en=1.
REQ-018 en=0 in any mode: nidx = idx, prescaler frozen, wrap=0; bcode SHALL be all-zero after the next edge.
REQ-019 Output bcode SHALL be registered as one-hot(nidx) when en=1 and all-zero when en=0; bcode SHALL never have more than one bit set.
REQ-020 wrap SHALL be 1 for exactly the cycle after a scan-up step from 2**N-1 to 0, or after a scan-down step from 0 to 2**N-1; it SHALL be 0 in direct mode even when in changes from max to 0.
REQ-021 Mode change (mode != mode_q): prescaler SHALL be cleared to 0 on that edge and no scan step SHALL occur on that edge; idx SHALL be kept, except that entering direct mode loads in per REQ-013.
REQ-022 Prescaler SHALL be held at 0 in direct mode.
REQ-023 Re-enabling (en 0->1) in a scan mode SHALL resume from the frozen idx and prescaler values; bcode SHALL reappear after one edge.
REQ-024 Scan steps SHALL start from the current idx; there is no implicit reload to 0.

Reset
REQ-025 On reset_n=0, asynchronously: idx=0, bcode=0, wrap=0, prescaler=0, mode_q=00.
REQ-026 On the first edge after reset_n rises, normal operation SHALL apply, with bcode still 0 until that edge.
REQ-027 Reset asserted mid-scan SHALL clear all state immediately, regardless of clk.

Verification
REQ-028 N=3, direct mode, en=1, sweep in 0..7 -> bcode = 8'h01..8'h80 one edge later, idx=in, wrap=0 throughout.
REQ-029 N=3, SCAN_DIV=4, scan-up from idx=6 -> idx 6,6,6,6,7,7,7,7,0; wrap=1 only in the cycle idx first reads 0; bcode 8'h40 -> 8'h80 -> 8'h01.
REQ-030 Scan-down from idx=0, SCAN_DIV=1 -> idx 0,7,6,5 on consecutive edges; wrap pulses once as idx goes 0->7.
REQ-031 Scan-up with en dropped for 5 cycles mid-count -> bcode=0 during the gap; idx and prescaler unchanged; stepping resumes with the remaining count.
REQ-032 Mode switch from scan-up to hold to scan-down on consecutive cycles -> no step on either switch edge; prescaler restarts from 0; idx constant across the switches.
REQ-033 reset_n pulsed low between edges during a scan with idx=5 -> bcode, idx and wrap read 0 before the next edge; bcode=8'h01 after the first edge following release, with en=1.
